// File: rtl/fhe_cpu_pkg.sv
// -----------------------------------------------------------------------------
// fhe_cpu_pkg
// Shared types, sizes and modular arithmetic helpers for the fhe_cpu RNS
// polynomial coprocessor.
//   - Sizes: N_SLOTS, N_PRIMES, COEF_W, NUM_REGS, D2_REG
//   - Q_PRIMES: RNS q basis, one modulus per residue lane
//   - q_basis_poly_t: one polynomial, indexed [slot][prime]
//   - mode_e / operation_t: operation descriptor driven by the host
// Optional build macro (used by the other files): CTCT_D2_WRITEBACK_EN
// -----------------------------------------------------------------------------
package fhe_cpu_pkg;

    localparam int N_SLOTS  = 8;
    localparam int N_PRIMES = 3;
    localparam int COEF_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int SLOT_W   = $clog2(N_SLOTS);

    localparam logic [REG_AW-1:0] D2_REG = REG_AW'(15);

    typedef logic [COEF_W-1:0] coef_t;

    localparam coef_t Q_PRIMES [N_PRIMES] = '{32'd17, 32'd257, 32'd65537};

    typedef coef_t [N_PRIMES-1:0] slot_t;
    typedef slot_t [N_SLOTS-1:0]  q_basis_poly_t;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_PT_MUL = 3'd3,
        OP_CT_CT_MUL = 3'd4
    } mode_e;

    typedef struct packed {
        mode_e             mode;
        logic [REG_AW-1:0] idx1_a;
        logic [REG_AW-1:0] idx1_b;
        logic [REG_AW-1:0] idx2_a;
        logic [REG_AW-1:0] idx2_b;
        logic [REG_AW-1:0] out_a;
        logic [REG_AW-1:0] out_b;
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Inputs are assumed already reduced, so one conditional subtract suffices.
    function automatic coef_t modadd(input coef_t x, input coef_t y, input coef_t q);
        logic [COEF_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, q})
            sum = sum - {1'b0, q};
        return coef_t'(sum);
    endfunction

    function automatic coef_t modmul(input coef_t x, input coef_t y, input coef_t q);
        logic [2*COEF_W-1:0] prod;
        prod = {{COEF_W{1'b0}}, x} * {{COEF_W{1'b0}}, y};
        return coef_t'(prod % {{COEF_W{1'b0}}, q});
    endfunction

    // Anything outside the four defined operations behaves as NO_OP.
    function automatic logic mode_valid(input mode_e m);
        case (m)
            OP_CT_CT_ADD, OP_CT_PT_ADD, OP_CT_PT_MUL, OP_CT_CT_MUL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fhe_cpu_rf_q.sv
// -----------------------------------------------------------------------------
// rf_q
// Polynomial register file for the q basis. Storage is not reset; the host
// preloads mem directly.
//   i_clk                 rising-edge clock
//   i_raddr_0..3          asynchronous read addresses
//   o_rdata_0..3          whole-polynomial read data
//   i_we_a/i_waddr_a/i_wdata_a   write port A
//   i_we_b/i_waddr_b/i_wdata_b   write port B (wins over A on same address)
//   i_we_d/i_wdata_d      degree-2 term write to D2_REG, lowest priority
//                         (present only with CTCT_D2_WRITEBACK_EN)
// -----------------------------------------------------------------------------
module rf_q
    import fhe_cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic [REG_AW-1:0] i_raddr_0,
    input  logic [REG_AW-1:0] i_raddr_1,
    input  logic [REG_AW-1:0] i_raddr_2,
    input  logic [REG_AW-1:0] i_raddr_3,
    output q_basis_poly_t     o_rdata_0,
    output q_basis_poly_t     o_rdata_1,
    output q_basis_poly_t     o_rdata_2,
    output q_basis_poly_t     o_rdata_3,
`ifdef CTCT_D2_WRITEBACK_EN
    input  logic              i_we_d,
    input  q_basis_poly_t     i_wdata_d,
`endif
    input  logic              i_we_a,
    input  logic [REG_AW-1:0] i_waddr_a,
    input  q_basis_poly_t     i_wdata_a,
    input  logic              i_we_b,
    input  logic [REG_AW-1:0] i_waddr_b,
    input  q_basis_poly_t     i_wdata_b
);

    q_basis_poly_t mem [NUM_REGS];

    assign o_rdata_0 = mem[i_raddr_0];
    assign o_rdata_1 = mem[i_raddr_1];
    assign o_rdata_2 = mem[i_raddr_2];
    assign o_rdata_3 = mem[i_raddr_3];

    // Later non-blocking assignments win, which sets the priority D < A < B.
    always_ff @(posedge i_clk) begin
`ifdef CTCT_D2_WRITEBACK_EN
        if (i_we_d)
            mem[D2_REG] <= i_wdata_d;
`endif
        if (i_we_a)
            mem[i_waddr_a] <= i_wdata_a;
        if (i_we_b)
            mem[i_waddr_b] <= i_wdata_b;
    end

endmodule

// File: rtl/fhe_cpu.sv
// -----------------------------------------------------------------------------
// fhe_cpu
// Single-issue RNS polynomial coprocessor. Latches one operation, computes it
// one slot per cycle across all primes, writes both result polynomials back in
// a single cycle, then pulses done_out.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (register file is not cleared)
//   op        operation descriptor, sampled only while idle
//   done_out  one-cycle completion pulse, N_SLOTS+2 cycles after issue
// Optional build macro: CTCT_D2_WRITEBACK_EN -- CT-CT multiply also writes
// its degree-2 term to D2_REG.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a valid op; op is latched on acceptance
// EXEC    | one slot per cycle into result buffers, slot 0..N_SLOTS-1
// WB      | result buffers written to out_a / out_b (and D2_REG)
// DONE    | schedules the registered done pulse, returns to IDLE
// -----------------------------------------------------------------------------
module fhe_cpu
    import fhe_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  operation_t op,
    output logic       done_out
);

    state_e            r_state;
    operation_t        r_op;
    logic [SLOT_W-1:0] r_slot;
    q_basis_poly_t     r_res_a;
    q_basis_poly_t     r_res_b;

    q_basis_poly_t     w_a1;
    q_basis_poly_t     w_b1;
    q_basis_poly_t     w_a2;
    q_basis_poly_t     w_b2;
    slot_t             w_slot_a;
    slot_t             w_slot_b;
    logic              w_we;

`ifdef CTCT_D2_WRITEBACK_EN
    q_basis_poly_t     r_res_d;
    slot_t             w_slot_d;
    logic              w_we_d;
`endif

    assign w_we = (r_state == ST_WB);

`ifdef CTCT_D2_WRITEBACK_EN
    assign w_we_d = w_we && (r_op.mode == OP_CT_CT_MUL);
`endif

    rf_q u_rf_q (
        .i_clk     (clk),
        .i_raddr_0 (r_op.idx1_a),
        .i_raddr_1 (r_op.idx1_b),
        .i_raddr_2 (r_op.idx2_a),
        .i_raddr_3 (r_op.idx2_b),
        .o_rdata_0 (w_a1),
        .o_rdata_1 (w_b1),
        .o_rdata_2 (w_a2),
        .o_rdata_3 (w_b2),
`ifdef CTCT_D2_WRITEBACK_EN
        .i_we_d    (w_we_d),
        .i_wdata_d (r_res_d),
`endif
        .i_we_a    (w_we),
        .i_waddr_a (r_op.out_a),
        .i_wdata_a (r_res_a),
        .i_we_b    (w_we),
        .i_waddr_b (r_op.out_b),
        .i_wdata_b (r_res_b)
    );

    // Per-slot datapath: all primes of the current slot in parallel.
    always_comb begin
        w_slot_a = '0;
        w_slot_b = '0;
`ifdef CTCT_D2_WRITEBACK_EN
        w_slot_d = '0;
`endif
        for (int p = 0; p < N_PRIMES; p++) begin
            case (r_op.mode)
                OP_CT_CT_ADD: begin
                    w_slot_a[p] = modadd(w_a1[r_slot][p], w_a2[r_slot][p], Q_PRIMES[p]);
                    w_slot_b[p] = modadd(w_b1[r_slot][p], w_b2[r_slot][p], Q_PRIMES[p]);
                end
                OP_CT_PT_ADD: begin
                    w_slot_a[p] = w_a1[r_slot][p];
                    w_slot_b[p] = modadd(w_b1[r_slot][p], w_a2[r_slot][p], Q_PRIMES[p]);
                end
                OP_CT_PT_MUL: begin
                    w_slot_a[p] = modmul(w_a1[r_slot][p], w_a2[r_slot][p], Q_PRIMES[p]);
                    w_slot_b[p] = modmul(w_b1[r_slot][p], w_a2[r_slot][p], Q_PRIMES[p]);
                end
                OP_CT_CT_MUL: begin
                    w_slot_a[p] = modadd(modmul(w_a1[r_slot][p], w_b2[r_slot][p], Q_PRIMES[p]),
                                         modmul(w_a2[r_slot][p], w_b1[r_slot][p], Q_PRIMES[p]),
                                         Q_PRIMES[p]);
                    w_slot_b[p] = modmul(w_b1[r_slot][p], w_b2[r_slot][p], Q_PRIMES[p]);
`ifdef CTCT_D2_WRITEBACK_EN
                    w_slot_d[p] = modmul(w_a1[r_slot][p], w_a2[r_slot][p], Q_PRIMES[p]);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_slot   <= '0;
            r_res_a  <= '0;
            r_res_b  <= '0;
`ifdef CTCT_D2_WRITEBACK_EN
            r_res_d  <= '0;
`endif
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mode_valid(op.mode)) begin
                        r_op    <= op;
                        r_slot  <= '0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_a[r_slot] <= w_slot_a;
                    r_res_b[r_slot] <= w_slot_b;
`ifdef CTCT_D2_WRITEBACK_EN
                    r_res_d[r_slot] <= w_slot_d;
`endif
                    if (r_slot == SLOT_W'(N_SLOTS - 1)) begin
                        r_slot  <= '0;
                        r_state <= ST_WB;
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
                ST_WB: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    done_out <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fhe_cpu.sv
module tb_fhe_cpu;
    import fhe_cpu_pkg::*;

    localparam int PW = N_SLOTS * N_PRIMES * COEF_W;
    localparam int unsigned QV [N_PRIMES] = '{17, 257, 65537};
    localparam int EXP_LAT = N_SLOTS + 2;

    logic       clk = 1'b0;
    logic       reset;
    operation_t op;
    logic       done_out;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned mdl [NUM_REGS][N_SLOTS][N_PRIMES];

    always #5 clk = ~clk;

    fhe_cpu dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .done_out (done_out)
    );

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic operation_t mk_op(input mode_e m, input int a1, input int b1,
                                         input int a2, input int b2, input int oa, input int ob);
        operation_t o;
        o.mode   = m;
        o.idx1_a = REG_AW'(a1);
        o.idx1_b = REG_AW'(b1);
        o.idx2_a = REG_AW'(a2);
        o.idx2_b = REG_AW'(b2);
        o.out_a  = REG_AW'(oa);
        o.out_b  = REG_AW'(ob);
        return o;
    endfunction

    function automatic operation_t rand_op();
        return mk_op(mode_e'(3'($urandom_range(1, 4))),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    endfunction

    function automatic q_basis_poly_t mdl_poly(input int r);
        q_basis_poly_t v;
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                v[s][p] = coef_t'(mdl[r][s][p]);
        return v;
    endfunction

    task automatic push_reg(input int r);
        dut.u_rf_q.mem[r] = mdl_poly(r);
    endtask

    task automatic fill_reg(input int r, input int unsigned val);
        for (int s = 0; s < N_SLOTS; s++)
            for (int p = 0; p < N_PRIMES; p++)
                mdl[r][s][p] = val;
        push_reg(r);
    endtask

    task automatic rand_all_regs();
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int s = 0; s < N_SLOTS; s++)
                for (int p = 0; p < N_PRIMES; p++)
                    mdl[r][s][p] = $urandom_range(0, QV[p] - 1);
            push_reg(r);
        end
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < NUM_REGS; r++)
            check($sformatf("%s_mem%0d", tag, r), dut.u_rf_q.mem[r], mdl_poly(r));
    endtask

    // Reference: arithmetic on plain integers, results committed after all reads.
    task automatic model_op(input operation_t o);
        int unsigned na [N_SLOTS][N_PRIMES];
        int unsigned nb [N_SLOTS][N_PRIMES];
        int unsigned nd [N_SLOTS][N_PRIMES];
        longint q, a1, b1, a2, b2;
        for (int s = 0; s < N_SLOTS; s++) begin
            for (int p = 0; p < N_PRIMES; p++) begin
                q  = QV[p];
                a1 = mdl[o.idx1_a][s][p];
                b1 = mdl[o.idx1_b][s][p];
                a2 = mdl[o.idx2_a][s][p];
                b2 = mdl[o.idx2_b][s][p];
                nd[s][p] = int'((a1 * a2) % q);
                case (o.mode)
                    OP_CT_CT_ADD: begin
                        na[s][p] = int'((a1 + a2) % q);
                        nb[s][p] = int'((b1 + b2) % q);
                    end
                    OP_CT_PT_ADD: begin
                        na[s][p] = int'(a1);
                        nb[s][p] = int'((b1 + a2) % q);
                    end
                    OP_CT_PT_MUL: begin
                        na[s][p] = int'((a1 * a2) % q);
                        nb[s][p] = int'((b1 * a2) % q);
                    end
                    default: begin
                        na[s][p] = int'((a1 * b2 + a2 * b1) % q);
                        nb[s][p] = int'((b1 * b2) % q);
                    end
                endcase
            end
        end
        if (!mode_valid(o.mode))
            return;
`ifdef CTCT_D2_WRITEBACK_EN
        if (o.mode == OP_CT_CT_MUL)
            mdl[15] = nd;
`endif
        mdl[o.out_a] = na;
        mdl[o.out_b] = nb;
    endtask

    // Issues one op, disturbs the op input while busy, checks latency, the
    // single-cycle pulse and the whole register file.
    task automatic run_op(input string tag, input operation_t o, input bit drop_now);
        int  lat;
        bit  got;
        @(negedge clk);
        op = o;
        @(posedge clk);
        #1;
        op = drop_now ? mk_op(NO_OP, 0, 0, 0, 0, 0, 0) : rand_op();
        lat = 0;
        got = 1'b0;
        while (lat < 30 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3)
                op.mode = NO_OP;
            if (done_out)
                got = 1'b1;
        end
        check({tag, "_latency"}, lat, EXP_LAT);
        model_op(o);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, done_out, 1'b0);
        check_all(tag);
    endtask

    initial begin
        int         highs;
        operation_t o;

        reset = 1'b0;
        op    = mk_op(NO_OP, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done_out, 1'b0);
        check("rst_state", dut.r_state, ST_IDLE);
        check("rst_slot", dut.r_slot, 0);
        @(negedge clk);
        reset = 1'b1;

        rand_all_regs();
        repeat (5) @(posedge clk);
        #1;
        for (int r = 0; r < 5; r++)
            check($sformatf("persist_mem%0d", r), dut.u_rf_q.mem[r], mdl_poly(r));
        check("idle_done", done_out, 1'b0);

        // CT-CT multiply with constant residues
        @(negedge clk);
        fill_reg(0, 2); fill_reg(1, 3); fill_reg(2, 5); fill_reg(3, 7);
        run_op("ctct_mul", mk_op(OP_CT_CT_MUL, 0, 1, 2, 3, 9, 10), 1'b0);
        check("ctct_mul_a_q17", dut.u_rf_q.mem[9][0][0], 12);
        check("ctct_mul_a_q257", dut.u_rf_q.mem[9][5][1], 29);
        check("ctct_mul_a_q65537", dut.u_rf_q.mem[9][7][2], 29);
        check("ctct_mul_b_q17", dut.u_rf_q.mem[10][3][0], 4);
        check("ctct_mul_b_q65537", dut.u_rf_q.mem[10][6][2], 21);

        // CT-PT add with wrap in the q=17 lane
        @(negedge clk);
        fill_reg(4, 16); fill_reg(5, 16); fill_reg(6, 5);
        run_op("ctpt_add", mk_op(OP_CT_PT_ADD, 4, 5, 6, 0, 7, 8), 1'b0);
        check("ctpt_add_b_wrap", dut.u_rf_q.mem[8][2][0], 4);
        check("ctpt_add_b_q257", dut.u_rf_q.mem[8][2][1], 21);
        check("ctpt_add_a", dut.u_rf_q.mem[7][4][0], 16);

        // Source register doubles as destination
        @(negedge clk);
        fill_reg(0, 2); fill_reg(2, 5);
        run_op("alias", mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 0, 11), 1'b0);
        check("alias_mem0", dut.u_rf_q.mem[0][1][1], 7);

        // op dropped to NO_OP one cycle after issue; then stay quiet
        @(negedge clk);
        rand_all_regs();
        run_op("drop", mk_op(OP_CT_PT_MUL, 1, 2, 3, 4, 5, 6), 1'b1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_out) highs++;
        end
        check("drop_quiet", highs, 0);

        // Reset during slot 3 of a CT-PT multiply
        @(negedge clk);
        rand_all_regs();
        op = mk_op(OP_CT_PT_MUL, 1, 2, 3, 4, 12, 13);
        @(posedge clk);
        #1;
        op.mode = NO_OP;
        repeat (3) @(posedge clk);
        #1;
        check("abort_at_slot3", dut.r_slot, 3);
        @(negedge clk);
        reset = 1'b0;
        highs = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done_out) highs++;
        end
        check("abort_state", dut.r_state, ST_IDLE);
        check("abort_slot", dut.r_slot, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done_out) highs++;
        end
        check("abort_no_done", highs, 0);
        check_all("abort");
        run_op("after_abort", mk_op(OP_CT_PT_MUL, 1, 2, 3, 4, 12, 13), 1'b0);

        // Randomized operations
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            rand_all_regs();
            run_op($sformatf("rnd%0d", k), rand_op(), 1'(k % 2));
        end

        // Undefined modes behave as NO_OP
        for (int k = 5; k < 8; k++) begin
            @(negedge clk);
            rand_all_regs();
            o = rand_op();
            o.mode = mode_e'(3'(k));
            op = o;
            highs = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (done_out) highs++;
            end
            op.mode = NO_OP;
            check($sformatf("badmode%0d_no_done", k), highs, 0);
            check_all($sformatf("badmode%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
